// File: rtl/link_tx_pkg.sv
// Shared types and constants for the FSK link transmitter and the PLL receiver bench.
package link_tx_pkg;

  typedef enum logic [2:0] {OFF, IDLE, PREAMBLE, DATA, GUARD} tx_state_t;
  typedef enum logic [1:0] {SEL_C, SEL_M, SEL_S} freq_sel_t;

  localparam int unsigned DEF_CLK_HZ = 100_000_000;
  localparam logic [31:0] DEF_F0     = 32'd40000;
  localparam logic [31:0] DEF_DELF   = 32'd5000;

  // floor(freq * 2^32 / clk_hz); the 64-bit numerator avoids overflow before the divide
  function automatic logic [31:0] phase_inc(input logic [31:0] freq, input logic [31:0] clk_hz);
    logic [63:0] num;
    num = {freq, 32'd0};
    return 32'(num / {32'd0, clk_hz});
  endfunction

  function automatic freq_sel_t bit_sel(input logic b);
    return b ? SEL_M : SEL_S;
  endfunction

endpackage

// File: rtl/link_nco.sv
// Phase accumulator; never cleared between symbols so the carrier stays phase-continuous.
module link_nco (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [31:0] inc,
  output logic        msb
);

  logic [31:0] acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (hold) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_reg + inc;
    end
  end

  assign msb = acc_reg[31];

endmodule

// File: rtl/link_fsk_tx.sv
// FSK link transmitter: preamble + LSB-first data symbols at F0+/-DELF, idles at F0.
module link_fsk_tx
  import link_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter logic [31:0] F0         = DEF_F0,
  parameter logic [31:0] DELF       = DEF_DELF,
  parameter int          SYM_CLKS   = 25000,
  parameter int          PRE_SYMS   = 4,
  parameter int          GUARD_SYMS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swipt_alive,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        link,
  output logic [31:0] f,
  output logic        busy
);

  localparam logic [31:0] F_M   = F0 + DELF;
  localparam logic [31:0] F_S   = F0 - DELF;
  localparam logic [31:0] INC_C = phase_inc(F0, CLK_HZ);
  localparam logic [31:0] INC_M = phase_inc(F_M, CLK_HZ);
  localparam logic [31:0] INC_S = phase_inc(F_S, CLK_HZ);

  localparam int SW   = (SYM_CLKS > 2) ? $clog2(SYM_CLKS) : 1;
  localparam int MAXS = (PRE_SYMS > 8) ? ((PRE_SYMS > GUARD_SYMS) ? PRE_SYMS : GUARD_SYMS)
                                       : ((GUARD_SYMS > 8) ? GUARD_SYMS : 8);
  localparam int IW   = $clog2(MAXS);

  localparam logic [SW-1:0] SYM_LAST   = SW'(SYM_CLKS - 1);
  localparam logic [SW-1:0] SYM_PENULT = SW'(SYM_CLKS - 2);
  localparam logic [IW-1:0] PRE_LAST   = IW'(PRE_SYMS - 1);
  localparam logic [IW-1:0] BIT_LAST   = IW'(7);
  localparam logic [IW-1:0] GUARD_LAST = IW'(GUARD_SYMS - 1);

  tx_state_t     state_reg;
  freq_sel_t     sel_reg;
  logic          tx_ready_reg;
  logic          busy_reg;
  logic [SW-1:0] sym_cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [7:0]    shreg_reg;

  logic          sym_end;
  logic          accept;
  logic          nco_hold;
  logic [31:0]   inc_sel;

  assign sym_end  = (sym_cnt_reg == SYM_LAST);
  // A dying power link wins over a handshake in the same cycle.
  assign accept   = tx_valid & tx_ready_reg & swipt_alive;
  // Clearing on the falling edge of swipt_alive makes link low together with OFF.
  assign nco_hold = !swipt_alive || (state_reg == OFF);

  always_comb begin
    inc_sel = INC_C;
    f       = F0;
    case (sel_reg)
      SEL_M:   begin inc_sel = INC_M; f = F_M; end
      SEL_S:   begin inc_sel = INC_S; f = F_S; end
      default: begin inc_sel = INC_C; f = F0;  end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= OFF;
      sel_reg      <= SEL_C;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      sym_cnt_reg  <= '0;
      idx_reg      <= '0;
      shreg_reg    <= '0;
    end else if (!swipt_alive) begin
      state_reg    <= OFF;
      sel_reg      <= SEL_C;
      tx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      sym_cnt_reg  <= '0;
      idx_reg      <= '0;
      shreg_reg    <= '0;
    end else begin
      tx_ready_reg <= 1'b0;
      sym_cnt_reg  <= sym_end ? '0 : sym_cnt_reg + 1'b1;
      case (state_reg)
        OFF: begin
          state_reg    <= IDLE;
          tx_ready_reg <= 1'b1;
          sym_cnt_reg  <= '0;
        end
        IDLE: begin
          sym_cnt_reg <= '0;
          if (accept) begin
            state_reg <= PREAMBLE;
            shreg_reg <= tx_data;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            sel_reg   <= SEL_M;
          end else begin
            tx_ready_reg <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (sym_end) begin
            if (idx_reg == PRE_LAST) begin
              state_reg <= DATA;
              idx_reg   <= '0;
              sel_reg   <= bit_sel(shreg_reg[0]);
            end else begin
              idx_reg <= idx_reg + 1'b1;
              // next index is even (mark) exactly when the current one is odd
              sel_reg <= bit_sel(idx_reg[0]);
            end
          end
        end
        DATA: begin
          if (idx_reg == BIT_LAST && sym_cnt_reg == SYM_PENULT) tx_ready_reg <= 1'b1;
          if (sym_end) begin
            if (idx_reg != BIT_LAST) begin
              idx_reg   <= idx_reg + 1'b1;
              shreg_reg <= shreg_reg >> 1;
              sel_reg   <= bit_sel(shreg_reg[1]);
            end else if (accept) begin
              shreg_reg <= tx_data;
              idx_reg   <= '0;
              sel_reg   <= bit_sel(tx_data[0]);
            end else begin
              state_reg <= GUARD;
              idx_reg   <= '0;
              sel_reg   <= SEL_C;
            end
          end
        end
        GUARD: begin
          if (sym_end) begin
            if (idx_reg == GUARD_LAST) begin
              state_reg    <= IDLE;
              idx_reg      <= '0;
              busy_reg     <= 1'b0;
              tx_ready_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= OFF;
      endcase
    end
  end

  assign tx_ready = tx_ready_reg;
  assign busy     = busy_reg;

  link_nco u_nco (
    .clk  (clk),
    .rst  (rst),
    .hold (nco_hold),
    .inc  (inc_sel),
    .msb  (link)
  );

endmodule

// File: tb/tb_link_fsk_tx.sv
// Directed bench for link_fsk_tx with a short symbol time and slow clock so frames stay small.
module tb_link_fsk_tx;

  localparam int unsigned CLK_HZ = 400_000;
  localparam int SYM   = 20;
  localparam int PRE   = 4;
  localparam int GUARD = 2;
  localparam int FC = 40000;
  localparam int FM = 45000;
  localparam int FS = 35000;

  logic        clk;
  logic        rst;
  logic        swipt_alive;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        link;
  logic [31:0] f;
  logic        busy;

  link_fsk_tx #(
    .CLK_HZ(CLK_HZ), .F0(32'd40000), .DELF(32'd5000),
    .SYM_CLKS(SYM), .PRE_SYMS(PRE), .GUARD_SYMS(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .swipt_alive(swipt_alive),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .link(link), .f(f), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // marks: expected symbol values in transmit order, written left (bit 0 sent) to right
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] marks;
  } vec_t;

  vec_t vecs [4];
  int   exp_f [32];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic fill_preamble();
    for (int k = 0; k < PRE; k++) exp_f[k] = (k % 2 == 0) ? FM : FS;
  endtask

  task automatic fill_bits(input logic [7:0] marks, input int base);
    for (int b = 0; b < 8; b++) exp_f[base + b] = marks[7 - b] ? FM : FS;
  endtask

  task automatic fill_guard(input int base);
    for (int g = 0; g < GUARD; g++) exp_f[base + g] = FC;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] first, input logic [7:0] second,
                           input bit b2b, input bit guard_valid, input int nsym, input int nbytes);
    int   got;
    int   busy_low;
    int   ready_hits;
    int   ready_first;
    int   min_run;
    int   run;
    int   r;
    bit   seen_edge;
    bit   drop;
    logic prev;
    check($sformatf("%s ready_before", tag), int'(tx_ready), 1, 1);
    tx_data  = first;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = b2b;
    tx_data  = second;
    busy_low = 0; ready_hits = 0; ready_first = -1; min_run = 1000; run = 0; r = 0;
    seen_edge = 1'b0; prev = link;
    for (int s = 0; s < nsym; s++) begin
      if (guard_valid && s >= nsym - GUARD) tx_valid = 1'b1;
      got = int'(f);
      for (int c = 0; c < SYM; c++) begin
        if (int'(f) != exp_f[s]) got = int'(f);
        if (!busy) busy_low++;
        if (tx_ready) begin
          ready_hits++;
          if (ready_first < 0) ready_first = r;
        end
        if (link == prev) run++;
        else begin
          if (seen_edge && run < min_run) min_run = run;
          seen_edge = 1'b1;
          run = 1;
        end
        prev = link;
        drop = tx_ready && tx_valid;
        r++;
        @(negedge clk);
        if (drop) tx_valid = 1'b0;
      end
      check($sformatf("%s sym%0d f", tag, s), got, exp_f[s], exp_f[s]);
    end
    check($sformatf("%s busy_low_cycles", tag), busy_low, 0, 0);
    check($sformatf("%s ready_pulses", tag), ready_hits, nbytes, nbytes);
    check($sformatf("%s first_ready_cycle", tag), ready_first, (PRE + 8) * SYM - 1, (PRE + 8) * SYM - 1);
    check($sformatf("%s min_link_run", tag), min_run, 4, 999);
    check($sformatf("%s busy_after", tag), int'(busy), 0, 0);
    check($sformatf("%s ready_after", tag), int'(tx_ready), 1, 1);
    check($sformatf("%s f_after", tag), int'(f), FC, FC);
    tx_valid = 1'b0;
    $display("frame %s: bytes=%0d symbols=%0d cycles=%0d", tag, nbytes, nsym, r);
  endtask

  initial begin
    int edge_t [2];
    int edges;
    int cyc;
    logic prev;

    vecs[0] = {8'hA5, 8'b10100101};
    vecs[1] = {8'h3C, 8'b00111100};
    vecs[2] = {8'h0E, 8'b01110000};
    vecs[3] = {8'h80, 8'b00000001};

    rst = 1'b1; swipt_alive = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #1;
    check("reset tx_ready", int'(tx_ready), 0, 0);
    check("reset busy", int'(busy), 0, 0);
    check("reset f", int'(f), FC, FC);
    check("reset link", int'(link), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle tx_ready", int'(tx_ready), 1, 1);
    check("idle f", int'(f), FC, FC);
    check("idle busy", int'(busy), 0, 0);
    $display("reset released, idle reached");

    // idle carrier period should be CLK_HZ/F0 = 10 clks
    edges = 0; cyc = 0; prev = link;
    while (edges < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (link && !prev) begin
        edge_t[edges] = cyc;
        edges++;
      end
      prev = link;
    end
    check("idle link period", (edges == 2) ? edge_t[1] - edge_t[0] : -1, 9, 11);

    for (int i = 0; i < 4; i++) begin
      fill_preamble();
      fill_bits(vecs[i].marks, PRE);
      fill_guard(PRE + 8);
      run_frame($sformatf("byte_%02h", vecs[i].data), vecs[i].data, 8'h00, 1'b0, (i == 1), PRE + 8 + GUARD, 1);
      repeat (3) @(negedge clk);
    end

    // back-to-back: 0x01 then 0xFF with tx_valid held
    fill_preamble();
    fill_bits(8'b10000000, PRE);
    fill_bits(8'b11111111, PRE + 8);
    fill_guard(PRE + 16);
    run_frame("b2b_01_ff", 8'h01, 8'hFF, 1'b1, 1'b0, PRE + 16 + GUARD, 2);
    repeat (3) @(negedge clk);

    // swipt_alive drop during data bit 3 of 0x5A
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat ((PRE + 3) * SYM + 5) @(negedge clk);
    check("drop pre busy", int'(busy), 1, 1);
    check("drop pre f bit3", int'(f), FM, FM);
    swipt_alive = 1'b0;
    @(negedge clk);
    check("drop link", int'(link), 0, 0);
    check("drop f", int'(f), FC, FC);
    check("drop busy", int'(busy), 0, 0);
    check("drop tx_ready", int'(tx_ready), 0, 0);
    repeat (3) @(negedge clk);
    check("off link held", int'(link), 0, 0);
    swipt_alive = 1'b1;
    @(negedge clk);
    check("reraise tx_ready", int'(tx_ready), 1, 1);
    repeat (SYM) @(negedge clk);
    check("reraise not resumed", int'(busy), 0, 0);
    $display("swipt drop during data handled");

    // handshake in the same cycle swipt_alive falls
    tx_data = 8'h33; tx_valid = 1'b1; swipt_alive = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    check("sameclk busy", int'(busy), 0, 0);
    check("sameclk tx_ready", int'(tx_ready), 0, 0);
    swipt_alive = 1'b1;
    @(negedge clk);
    check("sameclk idle ready", int'(tx_ready), 1, 1);
    repeat (4) @(negedge clk);
    check("sameclk not accepted", int'(busy), 0, 0);
    $display("same-cycle drop and handshake handled");

    // asynchronous reset in preamble symbol 1
    tx_data = 8'hC3; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (SYM + 3) @(negedge clk);
    check("prerst busy", int'(busy), 1, 1);
    check("prerst f", int'(f), FS, FS);
    #2 rst = 1'b1;
    #1;
    check("asyncrst busy", int'(busy), 0, 0);
    check("asyncrst tx_ready", int'(tx_ready), 0, 0);
    check("asyncrst f", int'(f), FC, FC);
    check("asyncrst link", int'(link), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst idle ready", int'(tx_ready), 1, 1);
    check("postrst busy", int'(busy), 0, 0);
    $display("async reset mid-preamble handled");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
